jtframe_linebuf_scan: RTL and testbench

- Consumer end of the tile/object layer line-buffer write interface: accepts (addr, data, wr) pixel writes plus a done flag from a layer renderer.
- Stores pixels in a ping-pong pair of line banks and scans the finished bank out at pixel rate, with horizontal scroll and flip.
- Generates the per-line stop/start handshake that drives the renderer.
- Sits between a layer renderer and the colour mixer.

---
 rtl/jtframe_linebuf_scan.sv | 164 ++++++++++++++++
 tb/tb_jtframe_linebuf_scan.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_linebuf_scan.sv
// Line-buffer consumer for a tile/object layer renderer.
// Two ping-pong line banks: the renderer fills one while the other is scanned out
// at pixel rate with horizontal scroll and flip. Each scanned location is cleared
// right after it is read, so pixels the renderer skips read as transparent.
// A small FSM produces the per-line stop/start handshake for the renderer.
module jtframe_linebuf_scan #(
    parameter int unsigned DW = 11,
    parameter int unsigned AW = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          pxl_cen,
    input  logic          LHBL,
    input  logic [AW-1:0] hdump,
    input  logic [AW-1:0] hpos,
    input  logic          flip,
    input  logic [AW-1:0] buf_addr,
    input  logic [DW-1:0] buf_data,
    input  logic          buf_wr,
    input  logic          done,
    output logic          start,
    output logic          stop,
    output logic [DW-1:0] pxl,
    output logic          late
);

    typedef enum logic [1:0] {StIdle, StStop, StStart, StBusy} state_e;

    state_e state_q, state_d;

    logic          lhbl_q;
    logic          line_edge;
    logic          miss_q, miss_d;          // renderer still busy at the line swap
    logic          done_seen_q, done_seen_d;
    logic          ready_q, ready_d;        // read bank holds a finished line
    logic          rd_bank_q, rd_bank_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          clr_q, clr_d;            // a read happened last clk: clear it now
    logic [DW-1:0] pxl_q, pxl_d;

    logic [AW-1:0] ra_sum;
    logic [AW-1:0] ra;
    logic          rd_en;
    logic          wr_en;

    logic [DW-1:0] mem0 [2**AW];
    logic [DW-1:0] mem1 [2**AW];
    logic [DW-1:0] ram_q;

    // Read address: scroll with 9-bit wrap, then mirror for flip
    always_comb begin
        ra_sum    = hdump + hpos;
        ra        = ra_sum ^ {AW{flip}};
        rd_en     = pxl_cen & LHBL;
        line_edge = lhbl_q & ~LHBL;
        wr_en     = (state_q == StBusy) & buf_wr;
    end

    // Renderer handshake: next-state and bank/ready bookkeeping
    always_comb begin
        state_d     = state_q;
        miss_d      = miss_q;
        done_seen_d = done_seen_q;
        ready_d     = ready_q;
        rd_bank_d   = rd_bank_q;
        unique case (state_q)
            StIdle: begin
                if (line_edge) begin
                    state_d = StStop;
                    miss_d  = 1'b0;
                end
            end
            StStop: begin
                ready_d   = done_seen_q;
                rd_bank_d = ~rd_bank_q;
                state_d   = StStart;
            end
            StStart: begin
                done_seen_d = 1'b0;
                state_d     = StBusy;
            end
            StBusy: begin
                // done in the boundary clk still counts as on time
                if (done) begin
                    done_seen_d = 1'b1;
                end
                if (line_edge) begin
                    state_d = StStop;
                    miss_d  = ~done;
                end else if (done) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        start = (state_q == StStart);
        stop  = (state_q == StStop) & miss_q;
        late  = (state_q == StStop) & miss_q;
        pxl   = pxl_q;
    end

    // Scan datapath next-state
    always_comb begin
        rd_addr_d = rd_addr_q;
        clr_d     = rd_en;
        pxl_d     = pxl_q;
        if (rd_en) begin
            rd_addr_d = ra;
        end
        if (!lhbl_q) begin
            pxl_d = '0;
        end else if (clr_q) begin
            pxl_d = ready_q ? ram_q : '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            lhbl_q      <= 1'b0;
            miss_q      <= 1'b0;
            done_seen_q <= 1'b0;
            ready_q     <= 1'b0;
            rd_bank_q   <= 1'b0;
            rd_addr_q   <= '0;
            clr_q       <= 1'b0;
            pxl_q       <= '0;
        end else begin
            state_q     <= state_d;
            lhbl_q      <= LHBL;
            miss_q      <= miss_d;
            done_seen_q <= done_seen_d;
            ready_q     <= ready_d;
            rd_bank_q   <= rd_bank_d;
            rd_addr_q   <= rd_addr_d;
            clr_q       <= clr_d;
            pxl_q       <= pxl_d;
        end
    end

    // Bank RAMs: renderer writes the write bank, clears go to the read bank,
    // so each bank sees at most one write per clk
    always_ff @(posedge clk) begin
        if (wr_en && rd_bank_q) begin
            mem0[buf_addr] <= buf_data;
        end else if (clr_q && !rd_bank_q) begin
            mem0[rd_addr_q] <= '0;
        end
        if (wr_en && !rd_bank_q) begin
            mem1[buf_addr] <= buf_data;
        end else if (clr_q && rd_bank_q) begin
            mem1[rd_addr_q] <= '0;
        end
        if (rd_en) begin
            ram_q <= rd_bank_q ? mem1[ra] : mem0[ra];
        end
    end

endmodule

// File: tb/tb_jtframe_linebuf_scan.sv
// Randomized scoreboard bench for jtframe_linebuf_scan.
// The driver plays both the video timing and the renderer; a reference model of
// the two line banks predicts every scanned pixel and handshake pulse, and a
// separate monitor compares DUT outputs against the queued expectations.
module tb_jtframe_linebuf_scan;

    localparam int DW = 11;
    localparam int AW = 9;
    localparam int N  = 512;
    localparam int NLINES = 15;
    localparam int BLANK  = 40;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pxl_cen;
    logic          LHBL;
    logic [AW-1:0] hdump;
    logic [AW-1:0] hpos;
    logic          flip;
    logic [AW-1:0] buf_addr;
    logic [DW-1:0] buf_data;
    logic          buf_wr;
    logic          done;
    logic          start;
    logic          stop;
    logic [DW-1:0] pxl;
    logic          late;

    jtframe_linebuf_scan #(.DW(DW), .AW(AW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pxl_cen  (pxl_cen),
        .LHBL     (LHBL),
        .hdump    (hdump),
        .hpos     (hpos),
        .flip     (flip),
        .buf_addr (buf_addr),
        .buf_data (buf_data),
        .buf_wr   (buf_wr),
        .done     (done),
        .start    (start),
        .stop     (stop),
        .pxl      (pxl),
        .late     (late)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int            due;
        logic [DW-1:0] val;
    } px_t;
    typedef struct {
        int       due;
        logic [2:0] v;   // {stop, late, start}
    } ct_t;

    px_t pxq[$];
    ct_t ctq[$];
    bit  mon_en = 1'b0;

    // Reference model state
    bit [DW-1:0] bank [2][N];
    bit rd_m        = 1'b0;
    bit ready_m     = 1'b0;
    bit done_seen_m = 1'b0;
    bit rend_busy   = 1'b0;
    bit go_pending  = 1'b0;
    bit job_on      = 1'b0;
    int job_idx     = 0;
    int job_mode    = 0;
    int wr_idx      = 0;
    int wr_total    = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Renderer job kinds: 0 done only, 1 ramp+done, 2 ramp never done,
    // 3 random writes with done on the last write, 4 random writes, done at line fall
    function automatic int mode_of(input int j);
        case (j)
            0, 6:       return 0;
            1, 2, 3, 4: return 1;
            5:          return 2;
            default:    return (j % 2 == 1) ? 3 : 4;
        endcase
    endfunction

    task automatic do_write(input int addr, input int data);
        buf_wr   = 1'b1;
        buf_addr = AW'(addr);
        buf_data = DW'(data);
        bank[!rd_m][addr] = DW'(data);
    endtask

    task automatic finish_job();
        done        = 1'b1;
        done_seen_m = 1'b1;
        rend_busy   = 1'b0;
        job_on      = 1'b0;
    endtask

    // One renderer step per clk, driven on the falling edge
    task automatic tick(input bit is_fall);
        buf_wr   = 1'b0;
        done     = 1'b0;
        buf_addr = AW'($urandom);
        buf_data = DW'($urandom);
        if (go_pending) begin
            go_pending = 1'b0;
            job_on     = 1'b1;
            rend_busy  = 1'b1;
            wr_idx     = 0;
            job_mode   = mode_of(job_idx);
            wr_total   = $urandom_range(1, 300);
            job_idx++;
        end else if (!rend_busy && $urandom_range(0, 3) == 0) begin
            // stray strobe outside BUSY: must not reach the RAM
            buf_wr = 1'b1;
        end
        if (job_on) begin
            case (job_mode)
                0: finish_job();
                1, 2: begin
                    if (wr_idx < 256) begin
                        do_write(wr_idx, wr_idx + 1);
                        wr_idx++;
                    end else if (job_mode == 1) begin
                        finish_job();
                    end
                end
                default: begin
                    if (wr_idx < wr_total) begin
                        if ($urandom_range(0, 3) != 0) begin
                            do_write($urandom_range(0, N - 1), $urandom);
                            wr_idx++;
                            if (wr_idx == wr_total && job_mode == 3) finish_job();
                        end
                    end else if (job_mode == 4 && is_fall) begin
                        finish_job();
                    end
                end
            endcase
        end
        if (start === 1'b1) go_pending = 1'b1;
    endtask

    // Monitor: compares handshake every clk and pixels when they fall due
    initial begin
        logic [2:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                e = 3'b000;
                if (ctq.size() > 0 && ctq[0].due == cyc) begin
                    e = ctq[0].v;
                    void'(ctq.pop_front());
                end
                check("stop_late_start", int'({stop, late, start}), int'(e));
                while (pxq.size() > 0 && pxq[0].due <= cyc) begin
                    if (pxq[0].due == cyc) check("pxl", int'(pxl), int'(pxq[0].val));
                    else check("pxl_missed_slot", pxq[0].due, cyc);
                    void'(pxq.pop_front());
                end
            end
        end
    end

    initial begin
        int ra;
        bit late_e;
        rst_n    = 1'b0;
        pxl_cen  = 1'b0;
        LHBL     = 1'b1;
        hdump    = '0;
        hpos     = '0;
        flip     = 1'b0;
        buf_addr = '0;
        buf_data = '0;
        buf_wr   = 1'b0;
        done     = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_pxl", int'(pxl), 0);
        check("reset_stop", int'(stop), 0);
        check("reset_start", int'(start), 0);
        check("reset_late", int'(late), 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        mon_en = 1'b1;

        for (int line = 0; line < NLINES; line++) begin
            if (line == 4) begin
                hpos = AW'(10);
                flip = 1'b0;
            end else if (line == 5) begin
                hpos = '0;
                flip = 1'b1;
            end else if (line >= 6) begin
                hpos = AW'($urandom);
                flip = 1'($urandom);
            end else begin
                hpos = '0;
                flip = 1'b0;
            end
            for (int h = 0; h < N; h++) begin
                @(negedge clk);
                pxl_cen = 1'b1;
                hdump   = AW'(h);
                ra = (h + int'(hpos)) % N;
                if (flip) ra = (N - 1) - ra;
                pxq.push_back('{due: cyc + 2, val: (ready_m ? bank[rd_m][ra] : DW'(0))});
                bank[rd_m][ra] = '0;
                tick(1'b0);
                @(negedge clk);
                pxl_cen = 1'b0;
                tick(1'b0);
            end
            // Line fall: renderer acts first so a done here wins over the swap
            @(negedge clk);
            LHBL    = 1'b0;
            pxl_cen = 1'($urandom);
            hdump   = AW'($urandom);
            tick(1'b1);
            late_e = rend_busy;
            ctq.push_back('{due: cyc + 1, v: {late_e, late_e, 1'b0}});
            ctq.push_back('{due: cyc + 2, v: 3'b001});
            pxq.push_back('{due: cyc + 2, val: DW'(0)});
            ready_m     = done_seen_m;
            rd_m        = !rd_m;
            done_seen_m = 1'b0;
            rend_busy   = 1'b0;
            job_on      = 1'b0;
            repeat (BLANK) begin
                @(negedge clk);
                pxl_cen = 1'($urandom);
                hdump   = AW'($urandom);
                tick(1'b0);
            end
            @(negedge clk);
            LHBL    = 1'b1;
            pxl_cen = 1'b0;
            tick(1'b0);
        end

        repeat (10) begin
            @(negedge clk);
            tick(1'b0);
        end
        @(negedge clk);
        check("queues_drained", pxq.size() + ctq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
